// File: rtl/aes_seq_pkg.sv
// Shared definitions for the AES job sequencer and its register file.
package aes_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWait,
        StReady
    } seq_state_e;

    // Sticky error flag bit positions
    localparam int unsigned ERR_OVF      = 0;
    localparam int unsigned ERR_BADSTART = 1;
    localparam int unsigned ERR_UNF      = 2;
    localparam int unsigned ERR_TMO      = 3;
    localparam int unsigned ERR_W        = 4;

    localparam int unsigned TEXT_W    = 128;
    localparam int unsigned KEY_W     = 256;
    localparam int unsigned TXT_CNT_W = 3;
    localparam int unsigned KEY_CNT_W = 4;

    // Register offsets decoded by the register file
    localparam logic [7:0] REG_CTRL     = 8'h04;
    localparam logic [7:0] REG_STATUS   = 8'h08;
    localparam logic [7:0] REG_WR_PORT0 = 8'h10;
    localparam logic [7:0] REG_WR_PORT1 = 8'h14;
    localparam logic [7:0] REG_WR_PORT2 = 8'h18;
    localparam logic [7:0] REG_WR_PORT3 = 8'h1C;
    localparam logic [7:0] REG_RD_PORT0 = 8'h20;
    localparam logic [7:0] REG_RD_PORT1 = 8'h24;

endpackage

// File: rtl/aes_seq_result_buf.sv
// Result capture buffer: holds one block, drained MSB word first, one word per read.
module aes_seq_result_buf #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned WORDS  = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clr_i,
    input  logic                      cap_i,
    input  logic [DATA_W*WORDS-1:0]   cap_data_i,
    input  logic                      rd_req_i,
    input  logic                      rd_en_i,
    output logic [DATA_W-1:0]         rd_data_o,
    output logic                      rd_valid_o,
    output logic                      empty_o,
    output logic                      last_o
);

    localparam int unsigned PtrW = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [DATA_W*WORDS-1:0] data_q, data_d;
    logic [PtrW-1:0]         ptr_q, ptr_d;
    logic                    empty_q, empty_d;
    logic [DATA_W-1:0]       rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    hit;

    assign hit    = rd_req_i && rd_en_i && !empty_q;
    assign last_o = hit && (ptr_q == PtrW'(WORDS - 1));

    // Next-state: capture/clear/pop; every read request gets a response, zero when not a hit
    always_comb begin
        data_d     = data_q;
        ptr_d      = ptr_q;
        empty_d    = empty_q;
        rd_valid_d = rd_req_i;
        rd_data_d  = '0;
        if (hit) begin
            for (int unsigned w = 0; w < WORDS; w++) begin
                if (ptr_q == PtrW'(w)) rd_data_d = data_q[DATA_W*(WORDS-w)-1 -: DATA_W];
            end
        end
        if (clr_i) begin
            empty_d = 1'b1;
            ptr_d   = '0;
        end else if (cap_i) begin
            data_d  = cap_data_i;
            empty_d = 1'b0;
            ptr_d   = '0;
        end else if (hit) begin
            ptr_d = ptr_q + PtrW'(1);
            if (last_o) empty_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q     <= '0;
            ptr_q      <= '0;
            empty_q    <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            ptr_q      <= ptr_d;
            empty_q    <= empty_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign empty_o    = empty_q;

endmodule

// File: rtl/aes_job_sequencer.sv
// Job sequencer between the register file and the AES-256 core.
// Optional watchdog enabled by defining AES_SEQ_TIMEOUT_EN.
module aes_job_sequencer
    import aes_seq_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TEXT_WORDS  = 4,
    parameter int unsigned KEY_WORDS   = 8,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                           clk_in1,
    input  logic                           reset,
    input  logic                           txt_wr,
    input  logic                           key_wr,
    input  logic [DATA_W-1:0]              wr_data,
    input  logic                           start_enc,
    input  logic                           start_dec,
    input  logic                           clr,
    input  logic                           rd_req,
    output logic [DATA_W-1:0]              rd_data,
    output logic                           rd_valid,
    output logic                           busy,
    output logic                           done,
    output logic [ERR_W-1:0]               err,
    output logic [TXT_CNT_W-1:0]           txt_cnt,
    output logic [KEY_CNT_W-1:0]           key_cnt,
    output logic                           core_start,
    output logic                           core_dec,
    output logic [DATA_W*TEXT_WORDS-1:0]   core_text,
    output logic [DATA_W*KEY_WORDS-1:0]    core_key,
    input  logic                           core_done,
    input  logic [DATA_W*TEXT_WORDS-1:0]   core_result
);

    seq_state_e                  state_q, state_d;
    logic [TXT_CNT_W-1:0]        txt_cnt_q, txt_cnt_d;
    logic [KEY_CNT_W-1:0]        key_cnt_q, key_cnt_d;
    logic [DATA_W*TEXT_WORDS-1:0] text_q, text_d;
    logic [DATA_W*KEY_WORDS-1:0]  key_q, key_d;
    logic                        core_dec_q, core_dec_d;
    logic                        core_start_q, core_start_d;
    logic [ERR_W-1:0]            err_q, err_d;
    logic                        load_ok, in_flight, accept;
    logic                        buf_clr, buf_cap, buf_empty, buf_last;
    logic                        wdog_expire;

    assign load_ok   = (state_q == StIdle) || (state_q == StReady);
    assign in_flight = (state_q == StLaunch) || (state_q == StWait);
    assign accept    = !clr && load_ok && (start_enc ^ start_dec)
                       && (txt_cnt_q == TXT_CNT_W'(TEXT_WORDS))
                       && (key_cnt_q == KEY_CNT_W'(KEY_WORDS));

`ifdef AES_SEQ_TIMEOUT_EN
    localparam int unsigned WdogW = $clog2(TIMEOUT_CYC) + 1;
    logic [WdogW-1:0] wdog_q, wdog_d;

    // Watchdog counts WAIT cycles from zero; expiry lands the count on TIMEOUT_CYC-1
    always_comb begin
        wdog_d = '0;
        if (state_q == StWait) wdog_d = wdog_q + WdogW'(1);
    end

    assign wdog_expire = (state_q == StWait) && (wdog_q == WdogW'(TIMEOUT_CYC - 2));

    // Watchdog register
    always_ff @(posedge clk_in1 or posedge reset) begin
        if (reset) wdog_q <= '0;
        else       wdog_q <= wdog_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign wdog_expire    = 1'b0;
`endif

    // Next-state: clear, job acceptance, operand loading, then FSM progress and errors
    always_comb begin
        state_d      = state_q;
        txt_cnt_d    = txt_cnt_q;
        key_cnt_d    = key_cnt_q;
        text_d       = text_q;
        key_d        = key_q;
        core_dec_d   = core_dec_q;
        core_start_d = 1'b0;
        err_d        = err_q;
        buf_clr      = 1'b0;
        buf_cap      = 1'b0;

        if (clr) begin
            err_d = '0;
            if (!in_flight) begin
                state_d   = StIdle;
                txt_cnt_d = '0;
                key_cnt_d = '0;
                buf_clr   = 1'b1;
            end
        end else begin
            if (accept) begin
                state_d      = StLaunch;
                core_dec_d   = start_dec;
                core_start_d = 1'b1;
                txt_cnt_d    = '0;
                key_cnt_d    = '0;
                buf_clr      = 1'b1;
            end else if (start_enc || start_dec) begin
                err_d[ERR_BADSTART] = 1'b1;
            end
            // Writes see the post-accept counters, so they start the next job's operands
            if (txt_wr) begin
                if (load_ok && (txt_cnt_d < TXT_CNT_W'(TEXT_WORDS))) begin
                    for (int unsigned w = 0; w < TEXT_WORDS; w++) begin
                        if (txt_cnt_d == TXT_CNT_W'(w))
                            text_d[DATA_W*(TEXT_WORDS-w)-1 -: DATA_W] = wr_data;
                    end
                    txt_cnt_d = txt_cnt_d + TXT_CNT_W'(1);
                end else begin
                    err_d[ERR_OVF] = 1'b1;
                end
            end
            if (key_wr) begin
                if (load_ok && (key_cnt_d < KEY_CNT_W'(KEY_WORDS))) begin
                    for (int unsigned w = 0; w < KEY_WORDS; w++) begin
                        if (key_cnt_d == KEY_CNT_W'(w))
                            key_d[DATA_W*(KEY_WORDS-w)-1 -: DATA_W] = wr_data;
                    end
                    key_cnt_d = key_cnt_d + KEY_CNT_W'(1);
                end else begin
                    err_d[ERR_OVF] = 1'b1;
                end
            end
        end

        unique case (state_q)
            StIdle: ;
            StLaunch: state_d = StWait;
            StWait: begin
                if (core_done) begin
                    buf_cap = 1'b1;
                    state_d = StReady;
                end else if (wdog_expire) begin
                    err_d[ERR_TMO] = 1'b1;
                    state_d        = StIdle;
                end
            end
            StReady: if (buf_last && (state_d == StReady)) state_d = StIdle;
        endcase

        if (rd_req && !((state_q == StReady) && !buf_empty)) err_d[ERR_UNF] = 1'b1;
    end

    // State registers
    always_ff @(posedge clk_in1 or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            txt_cnt_q    <= '0;
            key_cnt_q    <= '0;
            text_q       <= '0;
            key_q        <= '0;
            core_dec_q   <= 1'b0;
            core_start_q <= 1'b0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            txt_cnt_q    <= txt_cnt_d;
            key_cnt_q    <= key_cnt_d;
            text_q       <= text_d;
            key_q        <= key_d;
            core_dec_q   <= core_dec_d;
            core_start_q <= core_start_d;
            err_q        <= err_d;
        end
    end

    aes_seq_result_buf #(
        .DATA_W (DATA_W),
        .WORDS  (TEXT_WORDS)
    ) u_result_buf (
        .clk_i      (clk_in1),
        .rst_i      (reset),
        .clr_i      (buf_clr),
        .cap_i      (buf_cap),
        .cap_data_i (core_result),
        .rd_req_i   (rd_req),
        .rd_en_i    (state_q == StReady),
        .rd_data_o  (rd_data),
        .rd_valid_o (rd_valid),
        .empty_o    (buf_empty),
        .last_o     (buf_last)
    );

    assign busy       = in_flight;
    assign done       = !buf_empty;
    assign err        = err_q;
    assign txt_cnt    = txt_cnt_q;
    assign key_cnt    = key_cnt_q;
    assign core_start = core_start_q;
    assign core_dec   = core_dec_q;
    assign core_text  = text_q;
    assign core_key   = key_q;

endmodule

// File: tb/tb_aes_job_sequencer.sv
// Directed self-checking bench for aes_job_sequencer.
// Watchdog expectations follow AES_SEQ_TIMEOUT_EN.
module tb_aes_job_sequencer;

    localparam int unsigned T = 64;

    localparam logic [255:0] KEY =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         reset;
    logic         txt_wr, key_wr;
    logic [31:0]  wr_data;
    logic         start_enc, start_dec, clr, rd_req;
    logic [31:0]  rd_data;
    logic         rd_valid, busy, done;
    logic [3:0]   err;
    logic [2:0]   txt_cnt;
    logic [3:0]   key_cnt;
    logic         core_start, core_dec;
    logic [127:0] core_text;
    logic [255:0] core_key;
    logic         core_done;
    logic [127:0] core_result;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    aes_job_sequencer #(
        .DATA_W      (32),
        .TEXT_WORDS  (4),
        .KEY_WORDS   (8),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk_in1     (clk),
        .reset       (reset),
        .txt_wr      (txt_wr),
        .key_wr      (key_wr),
        .wr_data     (wr_data),
        .start_enc   (start_enc),
        .start_dec   (start_dec),
        .clr         (clr),
        .rd_req      (rd_req),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .txt_cnt     (txt_cnt),
        .key_cnt     (key_cnt),
        .core_start  (core_start),
        .core_dec    (core_dec),
        .core_text   (core_text),
        .core_key    (core_key),
        .core_done   (core_done),
        .core_result (core_result)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_txt(input logic [127:0] t, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            txt_wr  = 1'b1;
            wr_data = 32'(t >> (96 - 32 * i));
            tick();
        end
        txt_wr = 1'b0;
    endtask

    task automatic load_key(input logic [255:0] k);
        for (int i = 0; i < 8; i++) begin
            key_wr  = 1'b1;
            wr_data = 32'(k >> (224 - 32 * i));
            tick();
        end
        key_wr = 1'b0;
    endtask

    // Called in the cycle after core_start; core_done lands n cycles after core_start
    task automatic core_answer(input int n, input logic [127:0] r);
        for (int i = 1; i < n - 1; i++) tick();
        core_done   = 1'b1;
        core_result = r;
        tick();
        core_done   = 1'b0;
        core_result = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
    endtask

    task automatic read_chk(input string tag, input logic [31:0] exp);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk({tag, "_data"}, 256'(rd_data), 256'(exp));
        chk({tag, "_valid"}, 256'(rd_valid), 256'(1));
    endtask

    initial begin
        reset = 1'b1; txt_wr = 0; key_wr = 0; wr_data = '0; start_enc = 0; start_dec = 0;
        clr = 0; rd_req = 0; core_done = 0; core_result = '0;
        #12;
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_err", 256'(err), 256'(0));
        chk("rst_rdv", 256'(rd_valid), 256'(0));
        chk("rst_cstart", 256'(core_start), 256'(0));
        chk("rst_text", 256'(core_text), 256'(0));
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Encrypt, FIPS-197 AES-256 vector
        load_txt(PT, 0, 4);
        load_key(KEY);
        chk("enc_txtcnt", 256'(txt_cnt), 256'(4));
        chk("enc_keycnt", 256'(key_cnt), 256'(8));
        chk("enc_text", 256'(core_text), 256'(PT));
        chk("enc_key", core_key, KEY);
        start_enc = 1'b1;
        tick();
        start_enc = 1'b0;
        chk("enc_cstart", 256'(core_start), 256'(1));
        chk("enc_busy", 256'(busy), 256'(1));
        chk("enc_dec", 256'(core_dec), 256'(0));
        chk("enc_cnt_clr", 256'({txt_cnt, key_cnt}), 256'(0));
        tick();
        chk("enc_cstart_pulse", 256'(core_start), 256'(0));
        for (int i = 2; i < 40; i++) tick();
        chk("enc_wait_done", 256'(done), 256'(0));
        chk("enc_wait_busy", 256'(busy), 256'(1));
        core_done   = 1'b1;
        core_result = CT;
        tick();
        core_done   = 1'b0;
        core_result = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
        chk("enc_done", 256'(done), 256'(1));
        chk("enc_ready_busy", 256'(busy), 256'(0));
        read_chk("enc_w0", 32'h8ea2b7ca);
        read_chk("enc_w1", 32'h516745bf);
        read_chk("enc_w2", 32'heafc4990);
        chk("enc_done_w2", 256'(done), 256'(1));
        read_chk("enc_w3", 32'h4b496089);
        chk("enc_done_w3", 256'(done), 256'(0));
        read_chk("enc_w4", 32'h0);
        chk("enc_unf", 256'(err), 256'(4'b0100));
        tick();
        chk("enc_rdv_pulse", 256'(rd_valid), 256'(0));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_err", 256'(err), 256'(0));

        // Decrypt back to plaintext
        load_txt(CT, 0, 4);
        load_key(KEY);
        start_dec = 1'b1;
        tick();
        start_dec = 1'b0;
        chk("dec_cstart", 256'(core_start), 256'(1));
        chk("dec_dec", 256'(core_dec), 256'(1));
        chk("dec_text", 256'(core_text), 256'(CT));
        tick();
        core_answer(5, PT);
        chk("dec_done", 256'(done), 256'(1));
        chk("dec_dec_held", 256'(core_dec), 256'(1));
        read_chk("dec_w0", 32'h00112233);
        read_chk("dec_w1", 32'h44556677);
        read_chk("dec_w2", 32'h8899aabb);
        read_chk("dec_w3", 32'hccddeeff);
        chk("dec_err", 256'(err), 256'(0));

        // Missing operand rejects the start
        load_txt(PT, 0, 3);
        load_key(KEY);
        start_enc = 1'b1;
        tick();
        start_enc = 1'b0;
        chk("miss_cstart", 256'(core_start), 256'(0));
        chk("miss_err", 256'(err), 256'(4'b0010));
        chk("miss_txtcnt", 256'(txt_cnt), 256'(3));
        chk("miss_busy", 256'(busy), 256'(0));
        load_txt(PT, 3, 1);
        chk("miss_txtcnt4", 256'(txt_cnt), 256'(4));
        start_enc = 1'b1;
        tick();
        start_enc = 1'b0;
        chk("miss_retry", 256'(core_start), 256'(1));
        tick();
        core_answer(3, CT);
        chk("miss_done", 256'(done), 256'(1));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("miss_clr_done", 256'(done), 256'(0));
        chk("miss_clr_err", 256'(err), 256'(0));

        // Both starts together, then key overflow
        load_txt(PT, 0, 4);
        load_key(KEY);
        start_enc = 1'b1;
        start_dec = 1'b1;
        tick();
        start_enc = 1'b0;
        start_dec = 1'b0;
        chk("both_err", 256'(err), 256'(4'b0010));
        chk("both_busy", 256'(busy), 256'(0));
        chk("both_cstart", 256'(core_start), 256'(0));
        key_wr  = 1'b1;
        wr_data = 32'hffffffff;
        tick();
        key_wr  = 1'b0;
        chk("ovf_err", 256'(err), 256'(4'b0011));
        chk("ovf_keycnt", 256'(key_cnt), 256'(8));
        chk("ovf_key", core_key, KEY);
        clr = 1'b1;
        tick();
        clr = 1'b0;

        // Core never answers
        load_txt(PT, 0, 4);
        load_key(KEY);
        start_enc = 1'b1;
        tick();
        start_enc = 1'b0;
        chk("tmo_cstart", 256'(core_start), 256'(1));
        for (int i = 0; i < int'(T) - 1; i++) tick();
        chk("tmo_pre_err", 256'(err), 256'(0));
        chk("tmo_pre_busy", 256'(busy), 256'(1));
        tick();
`ifdef AES_SEQ_TIMEOUT_EN
        chk("tmo_err", 256'(err), 256'(4'b1000));
        chk("tmo_busy", 256'(busy), 256'(0));
        chk("tmo_done", 256'(done), 256'(0));
`else
        chk("notmo_err", 256'(err), 256'(0));
        chk("notmo_busy", 256'(busy), 256'(1));
`endif

        // Reset during WAIT, then a late core_done
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick();
        load_txt(PT, 0, 4);
        load_key(KEY);
        start_dec = 1'b1;
        tick();
        start_dec = 1'b0;
        tick();
        chk("rstw_busy_pre", 256'(busy), 256'(1));
        chk("rstw_dec_pre", 256'(core_dec), 256'(1));
        reset = 1'b1;
        #2;
        chk("rstw_busy", 256'(busy), 256'(0));
        chk("rstw_cstart", 256'(core_start), 256'(0));
        chk("rstw_dec", 256'(core_dec), 256'(0));
        chk("rstw_text", 256'(core_text), 256'(0));
        chk("rstw_key", core_key, 256'(0));
        chk("rstw_cnts", 256'({txt_cnt, key_cnt}), 256'(0));
        chk("rstw_err", 256'(err), 256'(0));
        chk("rstw_done", 256'(done), 256'(0));
        @(negedge clk);
        reset = 1'b0;
        tick();
        core_done   = 1'b1;
        core_result = PT;
        tick();
        core_done   = 1'b0;
        chk("late_done", 256'(done), 256'(0));
        chk("late_busy", 256'(busy), 256'(0));
        chk("late_rdv", 256'(rd_valid), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_job_sequencer.md
# aes_job_sequencer

Job sequencer between the AXI-lite register file and the AES-256 core. It collects plaintext/ciphertext words and key words, launches one encrypt or decrypt operation on the core, and waits for completion with an optional watchdog. It captures the 128-bit result into a read-out buffer that software drains one 32-bit word per read. The register file decodes the control register (offset 0x04), the status register (0x08), the write ports (0x10–0x1C) and the read ports (0x20/0x24) into the strobes below.

## Interface
Parameters:
- DATA_W, 32, register word width
- TEXT_WORDS, 4, words per 128-bit block
- KEY_WORDS, 8, words per 256-bit key
- TIMEOUT_CYC, 1024, watchdog limit in cycles from core_start

Ports:
- clk_in1  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; all state to reset values
- txt_wr  in  1  pulse: push wr_data into the text buffer
- key_wr  in  1  pulse: push wr_data into the key buffer
- wr_data  in  DATA_W  operand word, first written word is most significant
- start_enc  in  1  pulse: request an encrypt job
- start_dec  in  1  pulse: request a decrypt job
- clr  in  1  pulse: clear error flags, operand counters and result buffer
- rd_req  in  1  pulse: pop one result word
- rd_data  out  DATA_W  result word, reset 0
- rd_valid  out  1  rd_data qualifier, reset 0
- busy  out  1  job in flight, reset 0
- done  out  1  result buffer holds an unread result, reset 0
- err  out  4  sticky {timeout, underflow, bad_start, overflow}, reset 0
- txt_cnt  out  3  text words loaded, reset 0
- key_cnt  out  4  key words loaded, reset 0
- core_start  out  1  one-cycle launch pulse, reset 0
- core_dec  out  1  0 = encrypt, 1 = decrypt; held through the job, reset 0
- core_text  out  128  operand block, reset 0
- core_key  out  256  key, reset 0
- core_done  in  1  core completion strobe
- core_result  in  128  valid when core_done is high

## Operation
- States: IDLE, LAUNCH, WAIT, READY.
- Operand loading:
  - Word n is written to bits [127-32n -: 32] of the text register or [255-32n -: 32] of the key register.
  - Loading is allowed in IDLE and READY only. A write while busy, or beyond the buffer size, is dropped and sets err[0].
- Job acceptance:
  - IDLE/READY plus start_enc xor start_dec, with txt_cnt==4 and key_cnt==8, goes to LAUNCH.
  - On acceptance: latch core_dec, clear the result buffer, done and both counters. The operand registers keep their values.
- Rejected starts set err[1] and leave state unchanged. This covers:
  - start_enc and start_dec in the same cycle
  - missing operands
  - a start while busy
- LAUNCH: core_start=1 for one cycle, then WAIT.
- WAIT:
  - On core_done, capture core_result into the buffer, set done, go to READY.
  - On watchdog expiry, set err[3] and go to IDLE with done=0.
- READY, on rd_req:
  - Return word k (MSB first), k=0..3, and advance.
  - After word 3 is read, clear done and return to IDLE.
- rd_req in any other state, or with the buffer empty, returns rd_data=0 with rd_valid=1 and sets err[2].
- clr takes priority over all same-cycle writes and starts. It sends the FSM to IDLE unless busy; while busy it clears only the flags.
- busy=1 in LAUNCH and WAIT.

## Timing
- Start pulse at cycle t: core_start at t+1, busy at t+1.
- core_done at cycle c: done at c+1; a core_result that changes at c+1 is ignored.
- rd_req at t: rd_data and rd_valid at t+1, rd_valid for one cycle.
- Watchdog: counter starts at 0 in the cycle after core_start. It expires when the count reaches TIMEOUT_CYC-1 without core_done; core_done in the expiry cycle wins.
- A write strobe in the same cycle as an accepted start is applied after the counter clear, so it becomes word 0 of the next job.
- Asserting reset mid-job:
  - All outputs drop immediately to reset values; core_start is never glitched high.
  - A late core_done after reset is ignored because the FSM is in IDLE.

## Configuration
- AES_SEQ_TIMEOUT_EN defined: watchdog present; err[3] is set on expiry.
- AES_SEQ_TIMEOUT_EN undefined: no counter. WAIT holds until core_done; err[3] is tied to 0. TIMEOUT_CYC is unused.

## Structure
- Package aes_seq_pkg:
  - state enum
  - err bit indices (ERR_OVF=0, ERR_BADSTART=1, ERR_UNF=2, ERR_TMO=3)
  - width constants
  - the register offsets 0x04/0x08/0x10/0x14/0x18/0x1C/0x20/0x24 shared with the register file
- Sub-module aes_seq_result_buf: 4×32 capture buffer with read pointer, empty flag and registered rd_data/rd_valid.

## Test plan
- Encrypt, FIPS-197 vector: key 000102…1e1f, text 00112233445566778899aabbccddeeff, start_enc, core model answers after 40 cycles. Expected: reads return 8ea2b7ca, 516745bf, eafc4990, 4b496089; 5th read returns 0 with err[2] set.
- Decrypt of 8ea2b7ca516745bfeafc49904b496089 with the same key, start_dec. Expected: core_dec=1, reads return 00112233…ccddeeff in 4 words.
- Start with only 3 text words. Expected: no core_start, err[1]=1, txt_cnt stays 3. Fourth word plus start then succeeds.
- start_enc and start_dec in the same cycle. Expected: err[1]=1 and busy=0. A 9th key word sets err[0] with key_cnt=8.
- Core model never asserts core_done, macro defined. Expected: err[3]=1 exactly TIMEOUT_CYC cycles after core_start, FSM in IDLE. With the macro undefined, busy stays 1.
- reset asserted during WAIT, then core_done pulsed. Expected: all outputs at reset values, done stays 0.
